// File: rtl/mod_memarb_pkg.sv
// Shared encodings for the single-port memory arbiter.
// State, grant-owner and read/write command definitions.
package mod_memarb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } own_t;

   localparam int DRW_RD = 0;
   localparam int DRW_WR = 1;

   localparam logic [1:0] CMD_RD = 2'b01;
   localparam logic [1:0] CMD_WR = 2'b10;

   // 2'b11 resolves to a write, 2'b00 to a read.
   function automatic logic drw_is_write(input logic [1:0] drw);
      return drw[DRW_WR] || (drw == 2'b11);
   endfunction

   // Memory command actually issued for a data-port request.
   function automatic logic [1:0] drw_cmd(input logic [1:0] drw);
      return drw_is_write(drw) ? CMD_WR : CMD_RD;
   endfunction

endpackage

// File: rtl/mod_memarb.sv
// Arbiter/sequencer sharing one single-port memory between
// the instruction-fetch port and the data port.
import mod_memarb_pkg::*;

module mod_memarb #(
   parameter int LAT        = 1,
   parameter int STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_data,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [1:0]  d_drw,
   input  logic [31:0] d_din,
   output logic        d_ack,
   output logic [31:0] d_data,
   output logic        m_en,
   output logic [31:0] m_addr,
   output logic [1:0]  m_drw,
   output logic [31:0] m_din,
   input  logic [31:0] m_dout,
   output logic        busy
);

   localparam logic [2:0] LAT_M1 = 3'(LAT - 1);
   localparam logic [3:0] SMAX   = 4'(STARVE_MAX);

   state_t     state_q;
   state_t     state_n;
   logic [2:0] cnt_q;
   logic [2:0] cnt_n;
   logic [3:0] starve_q;
   logic [3:0] starve_n;
   own_t       own_q;
   own_t       own_n;
   logic       wr_q;
   logic       wr_n;
   logic       cap;
   logic       req_any;
   logic       pick_d;
   logic       d_wr;

   // Grant selection: data wins unless instruction fetch is starved.
   always_comb begin
      req_any = i_req | d_req;
      pick_d  = d_req & ~(i_req & (starve_q == SMAX));
      d_wr    = drw_is_write(d_drw);
   end

   // Next-state, memory strobe and ack generation.
   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      starve_n = starve_q;
      own_n    = own_q;
      wr_n     = wr_q;
      cap      = 1'b0;
      m_en     = 1'b0;
      m_addr   = '0;
      m_drw    = '0;
      m_din    = '0;
      i_ack    = 1'b0;
      d_ack    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_any && rst) begin
               m_en = 1'b1;
               if (pick_d) begin
                  own_n  = OWN_D;
                  wr_n   = d_wr;
                  m_addr = d_addr;
                  m_drw  = drw_cmd(d_drw);
                  m_din  = d_din;
                  if (i_req && (starve_q < SMAX))
                     starve_n = starve_q + 4'd1;
               end else begin
                  own_n    = OWN_I;
                  wr_n     = 1'b0;
                  m_addr   = i_addr;
                  m_drw    = CMD_RD;
                  starve_n = '0;
               end
               if (wr_n) begin
                  state_n = DONE;
               end else begin
                  state_n = WAIT;
                  cnt_n   = LAT_M1;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 3'd0) begin
               cap     = 1'b1;
               state_n = DONE;
            end else begin
               cnt_n = cnt_q - 3'd1;
            end
         end
         DONE: begin
            i_ack   = (own_q == OWN_I);
            d_ack   = (own_q == OWN_D);
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Sequencer state, latency counter and starvation counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         starve_q <= '0;
         own_q    <= OWN_I;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         starve_q <= starve_n;
         own_q    <= own_n;
         wr_q     <= wr_n;
      end
   end

   // Read data lands only in the register of the port that owns the read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_data <= '0;
         d_data <= '0;
      end else if (cap) begin
         if (own_q == OWN_D)
            d_data <= m_dout;
         else
            i_data <= m_dout;
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mod_memarb.sv
// Randomised and directed bench for mod_memarb.
// A transaction-level model predicts every cycle's outputs.
module tb_mod_memarb;

   localparam int LAT  = 3;
   localparam int SMAX = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_ack;
   logic [31:0] i_data;
   logic        d_req = 1'b0;
   logic [31:0] d_addr = '0;
   logic [1:0]  d_drw = '0;
   logic [31:0] d_din = '0;
   logic        d_ack;
   logic [31:0] d_data;
   logic        m_en;
   logic [31:0] m_addr;
   logic [1:0]  m_drw;
   logic [31:0] m_din;
   logic [31:0] m_dout;
   logic        busy;

   int checks = 0;
   int errors = 0;

   mod_memarb #(.LAT(LAT), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data),
      .d_req(d_req), .d_addr(d_addr), .d_drw(d_drw), .d_din(d_din),
      .d_ack(d_ack), .d_data(d_data),
      .m_en(m_en), .m_addr(m_addr), .m_drw(m_drw), .m_din(m_din),
      .m_dout(m_dout), .busy(busy)
   );

   always #5 clk = ~clk;

   // memory: 256 words, fixed read latency LAT
   logic [31:0] mem [256];
   logic [31:0] pipe [LAT];
   assign m_dout = pipe[LAT-1];

   always @(posedge clk) begin
      pipe[0] <= (m_en && !m_drw[1]) ? mem[m_addr[9:2]] : 32'hBAD0BAD0;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      if (m_en && m_drw[1]) mem[m_addr[9:2]] <= m_din;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // transaction-level model
   bit          active = 0;
   int          ack_at = 0;
   bit          mo_d = 0;
   bit          mo_wr = 0;
   int          starve = 0;
   logic [31:0] exp_i = '0;
   logic [31:0] exp_d = '0;
   logic [31:0] rd_val = '0;
   int          cyc = 0;
   logic        i_seen = 0;
   logic        d_seen = 0;

   always @(negedge clk) begin
      logic        e_men, e_iack, e_dack, e_busy, pd;
      logic [31:0] e_addr, e_din;
      logic [1:0]  e_drw;
      i_seen = i_ack;
      d_seen = d_ack;
      if (!rst) begin
         active = 0; starve = 0; exp_i = '0; exp_d = '0;
         chk("rst m_en", 32'(m_en), 0);
         chk("rst m_addr", m_addr, 0);
         chk("rst busy", 32'(busy), 0);
         chk("rst acks", 32'({i_ack, d_ack}), 0);
         chk("rst i_data", i_data, 0);
         chk("rst d_data", d_data, 0);
      end else begin
         e_men = 0; e_iack = 0; e_dack = 0; e_busy = active;
         e_addr = '0; e_din = '0; e_drw = '0;
         if (active) begin
            if (cyc == ack_at) begin
               if (!mo_wr) begin
                  if (mo_d) exp_d = rd_val; else exp_i = rd_val;
               end
               if (mo_d) e_dack = 1; else e_iack = 1;
               active = 0;
            end
         end else if (i_req || d_req) begin
            pd = d_req && !(i_req && starve == SMAX);
            if (pd) begin
               mo_wr = (d_drw == 2'b10) || (d_drw == 2'b11);
               e_addr = d_addr; e_din = d_din;
               e_drw = mo_wr ? 2'b10 : 2'b01;
               if (i_req && starve < SMAX) starve++;
            end else begin
               mo_wr = 0; e_addr = i_addr; e_din = '0; e_drw = 2'b01;
               starve = 0;
            end
            mo_d = pd; e_men = 1; active = 1;
            rd_val = mem[e_addr[9:2]];
            ack_at = cyc + (mo_wr ? 1 : LAT + 1);
         end
         chk("m_en", 32'(m_en), 32'(e_men));
         if (e_men) begin
            chk("m_addr", m_addr, e_addr);
            chk("m_drw", 32'(m_drw), 32'(e_drw));
            chk("m_din", m_din, e_din);
         end
         chk("i_ack", 32'(i_ack), 32'(e_iack));
         chk("d_ack", 32'(d_ack), 32'(e_dack));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("i_data", i_data, exp_i);
         chk("d_data", d_data, exp_d);
      end
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int g;
      logic [31:0] gl [5];
      logic [31:0] gexp [5];
      for (int k = 0; k < 256; k++) mem[k] = $urandom;
      mem[64] = 32'hDEADBEEF;
      mem[32] = 32'h0000CAFE;
      mem[33] = 32'h5555AAAA;

      // reset
      @(negedge clk);
      chk("reset busy", 32'(busy), 0);
      chk("reset i_data", i_data, 0);
      step();
      step();
      rst = 1'b1;
      step();

      // instruction read
      i_req = 1; i_addr = 32'h100;
      for (int k = 0; k <= LAT + 1; k++) begin
         @(negedge clk);
         if (k == 0) begin
            chk("t1 m_en", 32'(m_en), 1);
            chk("t1 m_addr", m_addr, 32'h100);
            chk("t1 m_drw", 32'(m_drw), 1);
            chk("t1 busy0", 32'(busy), 0);
         end else begin
            chk("t1 busy", 32'(busy), 1);
         end
         chk("t1 i_ack", 32'(i_ack), (k == LAT + 1) ? 1 : 0);
         if (k == LAT + 1) chk("t1 i_data", i_data, 32'hDEADBEEF);
         step();
      end
      i_req = 0;
      step();

      // data write
      d_req = 1; d_drw = 2'b10; d_addr = 32'h40; d_din = 32'h12345678;
      @(negedge clk);
      chk("t2 m_en", 32'(m_en), 1);
      chk("t2 m_drw", 32'(m_drw), 2);
      chk("t2 m_din", m_din, 32'h12345678);
      step();
      @(negedge clk);
      chk("t2 d_ack", 32'(d_ack), 1);
      chk("t2 d_data", d_data, 0);
      chk("t2 mem", mem[16], 32'h12345678);
      step();
      d_req = 0;
      step();

      // data read with LAT=3
      d_req = 1; d_drw = 2'b01; d_addr = 32'h80;
      for (int k = 0; k <= LAT + 1; k++) begin
         @(negedge clk);
         chk("t4 d_ack", 32'(d_ack), (k == 4) ? 1 : 0);
         chk("t4 i_ack", 32'(i_ack), 0);
         if (k == 4) begin
            chk("t4 d_data", d_data, 32'h0000CAFE);
            chk("t4 i_data", i_data, 32'hDEADBEEF);
         end
         step();
      end
      d_req = 0;
      step();

      // starvation bound
      gexp[0] = 32'h300; gexp[1] = 32'h300; gexp[2] = 32'h300;
      gexp[3] = 32'h200; gexp[4] = 32'h300;
      i_req = 1; i_addr = 32'h200;
      d_req = 1; d_addr = 32'h300; d_drw = 2'b01;
      g = 0;
      for (int c = 0; c < 80 && g < 5; c++) begin
         @(negedge clk);
         if (m_en && g < 5) begin gl[g] = m_addr; g++; end
         step();
         if (i_seen) i_req = 0;
         if (g == 5) d_req = 0;
      end
      chk("t3 grant count", g, 5);
      for (int k = 0; k < 5; k++)
         if (k < g) chk("t3 grant", gl[k], gexp[k]);
      for (int c = 0; c < 20 && busy; c++) step();
      chk("t3 idle", 32'(busy), 0);
      step();

      // req dropped after grant, pending instruction served next
      d_req = 1; d_addr = 32'h84; d_drw = 2'b01;
      @(negedge clk);
      chk("t6 m_addr", m_addr, 32'h84);
      step();
      d_req = 0; i_req = 1; i_addr = 32'h100;
      for (int k = 1; k <= 2 * LAT + 3; k++) begin
         @(negedge clk);
         if (k <= LAT + 1) chk("t6 quiet", 32'(m_en), 0);
         chk("t6 d_ack", 32'(d_ack), (k == LAT + 1) ? 1 : 0);
         if (k == LAT + 1) chk("t6 d_data", d_data, 32'h5555AAAA);
         if (k == LAT + 2) begin
            chk("t6 i grant", 32'(m_en), 1);
            chk("t6 i addr", m_addr, 32'h100);
         end
         chk("t6 i_ack", 32'(i_ack), (k == 2 * LAT + 3) ? 1 : 0);
         step();
      end
      i_req = 0;
      step();

      // reset during WAIT
      i_req = 1; i_addr = 32'h100;
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #3;
      rst = 0;
      #1;
      chk("t5 busy", 32'(busy), 0);
      chk("t5 i_data", i_data, 0);
      chk("t5 d_data", d_data, 0);
      chk("t5 m_en", 32'(m_en), 0);
      step();
      step();
      i_req = 0;
      rst = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t5 no ack", 32'({i_ack, d_ack}), 0);
         step();
      end
      d_req = 1; d_addr = 32'h80; d_drw = 2'b00;
      for (int k = 0; k <= LAT + 1; k++) begin
         @(negedge clk);
         chk("t5 d_ack", 32'(d_ack), (k == LAT + 1) ? 1 : 0);
         if (k == LAT + 1) chk("t5 d_data", d_data, 32'h0000CAFE);
         step();
      end
      d_req = 0;
      step();

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         if (i_req && i_seen) i_req = 0;
         if (d_req && d_seen) d_req = 0;
         if (!i_req && $urandom_range(0, 2) == 0) begin
            i_req = 1;
            i_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!d_req && $urandom_range(0, 1) == 0) begin
            d_req = 1;
            d_addr = $urandom & 32'hFFFF_FFFC;
            d_drw = 2'($urandom);
            d_din = $urandom;
         end
         step();
      end
      for (int c = 0; c < 40; c++) begin
         if (i_req && i_seen) i_req = 0;
         if (d_req && d_seen) d_req = 0;
         step();
      end
      chk("final idle", 32'({i_req, d_req, busy}), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mod_memarb.md
Name: mod_memarb

Overview:
- Two-requester arbiter and sequencer that shares one single-ported synchronous memory (inferred ROM/RAM, fixed read latency) between the CPU instruction-fetch port and data port.
- Sits between the CPU and the memory; replaces the dual-port ie/de path when the memory has only one port.
- Grants one transaction at a time, counts out the memory read latency, and returns data with a one-cycle ack pulse.
- Data port has priority, with a starvation bound that guarantees instruction fetch progress.

Parameters:
- LAT, 1, memory read latency in cycles from the m_en edge to valid m_dout (1..7).
- STARVE_MAX, 3, consecutive data grants made while an instruction request is pending before the instruction port is forced (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- i_req  in  1  instruction read request; held high until i_ack.
- i_addr  in  32  instruction byte address.
- i_ack  out  1  one-cycle pulse: i_data valid.
- i_data  out  32  last instruction word read; held between acks.
- d_req  in  1  data request; held high until d_ack.
- d_addr  in  32  data byte address.
- d_drw  in  2  bit1 = write, bit0 = read; 2'b11 is treated as write, 2'b00 as read.
- d_din  in  32  write data.
- d_ack  out  1  one-cycle pulse: read data valid or write committed.
- d_data  out  32  last data word read; held between acks.
- m_en  out  1  memory access strobe, one cycle per transaction.
- m_addr  out  32  memory address, valid while m_en is high.
- m_drw  out  2  memory read/write, valid while m_en is high.
- m_din  out  32  memory write data, valid while m_en is high.
- m_dout  in  32  memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, latency counter = 0, starvation counter = 0.
  - All outputs 0, including i_data and d_data.
- States are IDLE, WAIT and DONE.
- IDLE:
  - With no request, outputs stay quiescent (m_en = 0, acks = 0).
  - On any request: select the winner, drive m_en = 1 with the winner's addr/drw/din combinationally in that same cycle, and latch the grant owner and transaction type.
  - A read goes to WAIT with counter = LAT−1; a write goes to DONE.
- Arbitration when both ports request in IDLE:
  - The data port wins unless the starvation counter == STARVE_MAX; then the instruction port wins.
  - The starvation counter increments on each data grant made while i_req = 1, saturating at STARVE_MAX.
  - It clears on any instruction grant.
  - It holds when i_req = 0.
- Single requester: that requester is granted immediately.
- WAIT:
  - m_en = 0.
  - Decrement the counter each cycle. When the counter == 0, capture m_dout into the owner's data register (i_data or d_data) at that clock edge, then go to DONE.
- DONE:
  - Pulse the owner's ack for one cycle; go to IDLE.
  - No new grant is made in DONE, so a port's ack cycle never overlaps a new m_en.
- Latency, counted from the first cycle a request is seen in IDLE:
  - Read ack is LAT+1 cycles later; LAT = 1 gives ack in cycle 2.
  - Write ack is 1 cycle later.
  - Maximum throughput is one read per LAT+2 cycles and one write per 2 cycles.
- Handshake:
  - A requester holds req/addr/drw/din stable until its ack.
  - Addr/data are sampled only in the grant cycle; later changes are ignored.
  - If req drops mid-transaction, the transaction still completes, and the ack pulses and the data register updates regardless.
  - A req still high in the IDLE cycle after its ack is a new request.
- Ownership: a port's data register changes only on its own read completion. Writes never modify i_data or d_data.
- Address: passed through unmodified; word selection (e.g. addr[10:2]) belongs to the memory.
- Reset mid-transaction:
  - The transaction is aborted and no ack is produced.
  - A memory write already strobed may have committed.

Decomposition:
- Shared package holds:
  - the state encodings (IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2);
  - the drw bit positions (DRW_RD = 0, DRW_WR = 1);
  - the grant-owner encoding (OWN_I = 1'b0, OWN_D = 1'b1).
- No sub-module required. The grant selection is a small combinational block inside mod_memarb.

Test Plan:
1. Reset, then i_req=1, i_addr=0x100, LAT=1, memory returns 0xDEADBEEF: m_en in cycle 0 with m_addr=0x100 and m_drw=01; i_ack in cycle 2 with i_data=0xDEADBEEF; busy high in cycles 1–2.
2. d_req=1, d_drw=10, d_addr=0x40, d_din=0x12345678: m_en=1 with m_drw=10 and m_din=0x12345678 in cycle 0; d_ack in cycle 1; d_data is unchanged.
3. Simultaneous i_req and d_req reads, STARVE_MAX=3, d_req held continuously: data granted 3 times, the 4th grant goes to instruction, the starvation counter clears, and data is granted next.
4. LAT=3, data read of 0x0000CAFE: d_ack 4 cycles after the request, d_data=0x0000CAFE; i_data unchanged and no i_ack.
5. rst driven low asynchronously during WAIT: all outputs go to 0 immediately; no ack after release; the next request is handled normally from IDLE.
6. d_req dropped in the cycle after the grant: d_ack still pulses at LAT+1 and d_data updates; the arbiter then returns to IDLE and serves a pending i_req.
